benzerlik_biriktirici: RTL and testbench
========================================

BENZERLIK_BIRIKTIRICI -- requirements
Module: benzerlik_biriktirici

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 8, which sets the number of samples per frame; the legal range is 2..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port clr, input, 1 bit: synchronous abort of the current frame.
REQ-005 The block SHALL have port hb_in, input, 3 bits: similarity score from the 4-bit similarity stage; legal values are 0..4.
REQ-006 The block SHALL have port hb_valid, input, 1 bit: hb_in is valid this cycle.
REQ-007 The block SHALL have port hb_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-008 The block SHALL have port sum_out, output, 6 bits: sum of the scores in the frame.
REQ-009 The block SHALL have port max_out, output, 3 bits: highest score in the frame.
REQ-010 The block SHALL have port perfect_cnt, output, 4 bits: number of samples in the frame with a score of 4.
REQ-011 The block SHALL have port err_out, output, 1 bit: at least one illegal score (5..7) was seen in the frame.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the frame result is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-014 The block SHALL implement a two-state FSM with states ACCUM and DONE; the state after reset is ACCUM.
REQ-015 In ACCUM: hb_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 In DONE: hb_ready SHALL be 0 and out_valid SHALL be 1.
REQ-017 A sample SHALL be accepted only on a clock edge where hb_valid=1, hb_ready=1 and clr=0.
REQ-018 Each accepted sample SHALL update the working registers: sum_acc += score; max_acc = max(max_acc, score); perf_acc += (score==4); sample counter += 1.
REQ-019 Scores of 5..7 SHALL be saturated to 4 for the sum, max and perfect count, and SHALL set the working error flag.
REQ-020 An accepted sample that makes the counter reach FRAME_LEN SHALL, on the same edge, load the result registers from the working values including that sample, clear the working registers and counter, and move the FSM to DONE.
REQ-021 out_valid SHALL rise in the cycle after the last sample of the frame is accepted, giving a latency of 1 cycle.
REQ-022 sum_out, max_out, perfect_cnt and err_out SHALL be driven only from the result registers, which SHALL stay stable throughout DONE and hold the last frame's values while in ACCUM.
REQ-023 In DONE, if out_ready=1 on a clock edge, the FSM SHALL move to ACCUM; hb_ready rises the next cycle, and no sample is accepted in the handshake cycle.
REQ-024 In DONE, if out_ready=0, the block SHALL stay in DONE indefinitely, and samples on hb_in SHALL be neither accepted nor lost.
REQ-025 In ACCUM, clr=1 SHALL clear the working registers and counter, and SHALL take precedence over a simultaneous hb_valid.
REQ-026 In DONE, clr SHALL have no effect.
REQ-027 The maximum sum SHALL be 4*15=60, so it fits in 6 bits and no overflow is possible.
REQ-028 The counter SHALL be 4 bits and SHALL wrap to 0 only via the frame-complete load.
REQ-029 The block SHALL contain no combinational path from hb_valid to hb_ready, or from out_ready to out_valid.

Reset
REQ-030 While rst_n=0, the block SHALL set: state=ACCUM, hb_ready=1, out_valid=0, sum_out=0, max_out=0, perfect_cnt=0, err_out=0, and working registers and counter to 0.
REQ-031 Reset SHALL take effect immediately, without waiting for a clock edge, including in the middle of a frame or during DONE.
REQ-032 After reset the block SHALL discard any partial frame, and no out_valid SHALL appear until FRAME_LEN new samples have been accepted.

Verification
REQ-033 With FRAME_LEN=8, send scores 4,4,3,2,4,0,1,4 back-to-back -> one cycle after the 8th sample: out_valid=1, sum_out=22, max_out=4, perfect_cnt=4, err_out=0.
REQ-034 Apply 8 samples with score 1 with hb_valid toggling every other cycle -> sum_out=8, max_out=1, perfect_cnt=0; out_valid appears exactly one cycle after the 8th accepted sample.
REQ-035 Hold out_ready=0 for 5 cycles in DONE while hb_valid=1 with score 4 -> hb_ready=0 and outputs unchanged for all 5 cycles; after out_ready=1, the following 8 samples form a new, correct frame.
REQ-036 Include score 6 once among seven 0s -> sum_out=4, max_out=4, perfect_cnt=1, err_out=1; the next clean frame gives err_out=0.
REQ-037 Send 3 samples, then apply clr=1 together with hb_valid=1, then send 8 samples of score 2 -> result sum_out=16; the clr-cycle sample is not counted.
REQ-038 Drive rst_n low between clock edges after 5 samples -> all outputs go to reset values at once; after release, 8 samples of score 3 give sum_out=24.

Source files
------------

// File: rtl/benzerlik_biriktirici.sv
// Similarity-score frame accumulator: sums, tracks max, counts perfect scores
// and flags illegal scores over FRAME_LEN samples, then holds the result until acked.
module benzerlik_biriktirici #(
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [2:0] hb_in,
  input  logic       hb_valid,
  output logic       hb_ready,
  output logic [5:0] sum_out,
  output logic [2:0] max_out,
  output logic [3:0] perfect_cnt,
  output logic       err_out,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int unsigned SCORE_W = 3;
  localparam int unsigned SUM_W   = 6;
  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(4);

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  state_t state, state_next;

  logic [SUM_W-1:0]   sum_acc, sum_nxt;
  logic [SCORE_W-1:0] max_acc, max_nxt;
  logic [CNT_W-1:0]   perf_acc, perf_nxt;
  logic               err_acc, err_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [SCORE_W-1:0] score_sat;
  logic               accept;
  logic               frame_end;

  // Handshake flags decode straight from the state flop, so no input reaches them.
  assign hb_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  // Next-state, sample acceptance and working-value update
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    frame_end  = 1'b0;
    score_sat  = (hb_in > SCORE_TOP) ? SCORE_TOP : hb_in;
    sum_nxt    = sum_acc + SUM_W'(score_sat);
    max_nxt    = (score_sat > max_acc) ? score_sat : max_acc;
    perf_nxt   = perf_acc + CNT_W'(score_sat == SCORE_TOP);
    err_nxt    = err_acc | (hb_in > SCORE_TOP);
    case (state)
      ACCUM: begin
        accept    = hb_valid && !clr;
        frame_end = accept && (cnt == LAST_IDX);
        if (frame_end) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // Working and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_acc     <= '0;
      max_acc     <= '0;
      perf_acc    <= '0;
      err_acc     <= 1'b0;
      cnt         <= '0;
      sum_out     <= '0;
      max_out     <= '0;
      perfect_cnt <= '0;
      err_out     <= 1'b0;
    end else if (state == ACCUM) begin
      if (clr || frame_end) begin
        sum_acc  <= '0;
        max_acc  <= '0;
        perf_acc <= '0;
        err_acc  <= 1'b0;
        cnt      <= '0;
      end else if (accept) begin
        sum_acc  <= sum_nxt;
        max_acc  <= max_nxt;
        perf_acc <= perf_nxt;
        err_acc  <= err_nxt;
        cnt      <= cnt + CNT_W'(1);
      end
      // Result includes the frame-completing sample itself.
      if (frame_end) begin
        sum_out     <= sum_nxt;
        max_out     <= max_nxt;
        perfect_cnt <= perf_nxt;
        err_out     <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_benzerlik_biriktirici.sv
// Directed bench for benzerlik_biriktirici with hand-computed frame results.
module tb_benzerlik_biriktirici;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [2:0] hb_in;
  logic       hb_valid;
  logic       hb_ready;
  logic [5:0] sum_out;
  logic [2:0] max_out;
  logic [3:0] perfect_cnt;
  logic       err_out;
  logic       out_valid;
  logic       out_ready;

  int n_vec = 0;
  int n_err = 0;

  benzerlik_biriktirici #(.FRAME_LEN(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .hb_in      (hb_in),
    .hb_valid   (hb_valid),
    .hb_ready   (hb_ready),
    .sum_out    (sum_out),
    .max_out    (max_out),
    .perfect_cnt(perfect_cnt),
    .err_out    (err_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] s);
    hb_valid = 1'b1;
    hb_in    = s;
    tick();
    hb_valid = 1'b0;
  endtask

  task automatic check_res(input string tag, input int s, input int m, input int p, input int e);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_ready"}, int'(hb_ready), 0);
    chk({tag, "_sum"}, int'(sum_out), s);
    chk({tag, "_max"}, int'(max_out), m);
    chk({tag, "_perf"}, int'(perfect_cnt), p);
    chk({tag, "_err"}, int'(err_out), e);
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ack_valid"}, int'(out_valid), 0);
    chk({tag, "_ack_ready"}, int'(hb_ready), 1);
  endtask

  initial begin
    logic [2:0] v33 [8];
    v33 = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1, 3'd4};
    rst_n = 1'b0; clr = 1'b0; hb_in = '0; hb_valid = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_ready", int'(hb_ready), 1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sum", int'(sum_out), 0);
    chk("rst_max", int'(max_out), 0);
    chk("rst_perf", int'(perfect_cnt), 0);
    chk("rst_err", int'(err_out), 0);
    #9 rst_n = 1'b1;
    tick();

    // Back-to-back frame
    for (int i = 0; i < 8; i++) begin
      send(v33[i]);
      if (i == 6) chk("b2b_early_valid", int'(out_valid), 0);
    end
    check_res("b2b", 22, 4, 4, 0);
    ack("b2b");
    chk("b2b_hold_sum", int'(sum_out), 22);

    // hb_valid toggling every other cycle
    for (int i = 0; i < 8; i++) begin
      send(3'd1);
      if (i == 7) check_res("gap", 8, 1, 0, 0);
      else begin
        chk("gap_early_valid", int'(out_valid), 0);
        tick();
      end
    end

    // Backpressure: samples offered during DONE are not accepted
    hb_valid = 1'b1; hb_in = 3'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_res("stall", 8, 1, 0, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; hb_valid = 1'b0;
    chk("stall_ack_ready", int'(hb_ready), 1);
    chk("stall_ack_valid", int'(out_valid), 0);
    for (int i = 0; i < 8; i++) begin
      send(3'd4);
      if (i == 6) chk("stall_next_early", int'(out_valid), 0);
    end
    check_res("stall_next", 32, 4, 8, 0);
    ack("stall_next");

    // Illegal score saturates and flags
    for (int i = 0; i < 8; i++) send((i == 3) ? 3'd6 : 3'd0);
    check_res("illegal", 4, 4, 1, 1);
    ack("illegal");
    for (int i = 0; i < 8; i++) send(3'd2);
    check_res("clean", 16, 2, 0, 0);
    ack("clean");

    // clr aborts partial frame and wins over hb_valid
    for (int i = 0; i < 3; i++) send(3'd3);
    clr = 1'b1; hb_valid = 1'b1; hb_in = 3'd4;
    tick();
    clr = 1'b0; hb_valid = 1'b0;
    chk("clr_ready", int'(hb_ready), 1);
    for (int i = 0; i < 8; i++) begin
      send(3'd2);
      if (i == 4) chk("clr_early_valid", int'(out_valid), 0);
    end
    check_res("clr", 16, 2, 0, 0);
    ack("clr");

    // Asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) send(3'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum", int'(sum_out), 0);
    chk("arst_max", int'(max_out), 0);
    chk("arst_ready", int'(hb_ready), 1);
    chk("arst_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      send(3'd3);
      if (i == 6) chk("arst_early_valid", int'(out_valid), 0);
    end
    check_res("arst", 24, 3, 0, 0);

    // Asynchronous reset during DONE
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done_valid", int'(out_valid), 0);
    chk("arst_done_sum", int'(sum_out), 0);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
